fire_sched: RTL

FIRE_SCHED -- requirements
Module: fire_sched

---
 rtl/fire_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/fire_sched.sv
// Multi-channel ignition scheduler: per-channel delay-then-dwell coil drive with abort on sync loss.
// Optional dwell clamp with sticky overdwell flag is enabled by defining FIRE_SCHED_OVERDWELL_EN.
module fire_sched #(
  parameter int             NCH       = 4,
  parameter int             TW        = 16,
  parameter logic [TW-1:0]  MAX_DWELL = 16'd12000,
  localparam int            CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           synced,
  input  logic           arm_valid,
  input  logic [CW-1:0]  arm_ch,
  input  logic [TW-1:0]  arm_delay,
  input  logic [TW-1:0]  arm_dwell,
  output logic           arm_ready,
  output logic [NCH-1:0] ign,
  output logic [NCH-1:0] busy,
  output logic [NCH-1:0] fired,
  output logic           overdwell
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DWELL = 2'd2
  } ch_state_t;

  ch_state_t        state_r [NCH];
  ch_state_t        state_s [NCH];
  logic [TW-1:0]    cnt_r   [NCH];
  logic [TW-1:0]    cnt_s   [NCH];
  logic [TW-1:0]    dwell_r [NCH];
  logic [TW-1:0]    dwell_s [NCH];
  logic [NCH-1:0]   ign_r, busy_r, fired_r;
  logic [NCH-1:0]   ign_s, busy_s, fired_s;
  logic             overdwell_r;
  logic             arm_ready_s;
  logic             accept_s;
  logic [TW-1:0]    dwell_ld_s;
  logic             od_set_s;

  // Arm handshake: only an idle target channel with valid crank sync can take a request
  always_comb begin
    arm_ready_s = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (arm_ch == CW'(i)) begin
        arm_ready_s = synced && !reset && (state_r[i] == IDLE);
      end else begin
        arm_ready_s = arm_ready_s;
      end
    end
    accept_s = arm_valid && arm_ready_s;
  end

`ifdef FIRE_SCHED_OVERDWELL_EN
  // Dwell clamp: oversize requests are shortened and flagged
  always_comb begin
    if (arm_dwell > MAX_DWELL) begin
      dwell_ld_s = MAX_DWELL;
      od_set_s   = accept_s;
    end else begin
      dwell_ld_s = arm_dwell;
      od_set_s   = 1'b0;
    end
  end
`else
  logic [TW-1:0] unused_max_dwell_s;
  assign unused_max_dwell_s = MAX_DWELL;

  // Dwell passes through untouched when clamping is not built in
  always_comb begin
    dwell_ld_s = arm_dwell;
    od_set_s   = 1'b0;
  end
`endif

  // Per-channel next state: WAIT counts delay to 0, DWELL counts dwell-1 to 0
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_s[i] = state_r[i];
      cnt_s[i]   = cnt_r[i];
      dwell_s[i] = dwell_r[i];
      fired_s[i] = 1'b0;
      if (!synced) begin
        state_s[i] = IDLE;
        cnt_s[i]   = {TW{1'b0}};
      end else begin
        case (state_r[i])
          IDLE: begin
            // a zero dwell is accepted but leaves the channel idle
            if (accept_s && (arm_ch == CW'(i)) && (dwell_ld_s != {TW{1'b0}})) begin
              state_s[i] = WAIT;
              cnt_s[i]   = arm_delay;
              dwell_s[i] = dwell_ld_s;
            end else begin
              state_s[i] = IDLE;
            end
          end
          WAIT: begin
            if (cnt_r[i] == {TW{1'b0}}) begin
              state_s[i] = DWELL;
              cnt_s[i]   = dwell_r[i] - {{(TW-1){1'b0}}, 1'b1};
            end else begin
              cnt_s[i]   = cnt_r[i] - {{(TW-1){1'b0}}, 1'b1};
            end
          end
          DWELL: begin
            if (cnt_r[i] == {TW{1'b0}}) begin
              state_s[i] = IDLE;
              fired_s[i] = 1'b1;
            end else begin
              cnt_s[i]   = cnt_r[i] - {{(TW-1){1'b0}}, 1'b1};
            end
          end
          default: begin
            state_s[i] = IDLE;
            cnt_s[i]   = {TW{1'b0}};
          end
        endcase
      end
      ign_s[i]  = (state_s[i] == DWELL);
      busy_s[i] = (state_s[i] != IDLE);
    end
  end

  // State, counters and registered outputs; reset wins over abort and arm
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= IDLE;
        cnt_r[i]   <= {TW{1'b0}};
        dwell_r[i] <= {TW{1'b0}};
      end
      ign_r       <= {NCH{1'b0}};
      busy_r      <= {NCH{1'b0}};
      fired_r     <= {NCH{1'b0}};
      overdwell_r <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_r[i] <= state_s[i];
        cnt_r[i]   <= cnt_s[i];
        dwell_r[i] <= dwell_s[i];
      end
      ign_r       <= ign_s;
      busy_r      <= busy_s;
      fired_r     <= fired_s;
      overdwell_r <= overdwell_r | od_set_s;
    end
  end

  assign arm_ready = arm_ready_s;
  assign ign       = ign_r;
  assign busy      = busy_r;
  assign fired     = fired_r;
  assign overdwell = overdwell_r;

endmodule
